// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared encodings for the board/move packet loader
package tpu_pkg;

  // Square contents: piece kind in the low bits, colour in the top two bits
  localparam logic [7:0] EMPTY  = 8'h00;
  localparam logic [7:0] KING   = 8'h01;
  localparam logic [7:0] QUEEN  = 8'h02;
  localparam logic [7:0] BISHOP = 8'h03;
  localparam logic [7:0] ROOK   = 8'h04;
  localparam logic [7:0] KNIGHT = 8'h05;
  localparam logic [7:0] PAWN   = 8'h06;
  localparam logic [7:0] WHITE  = 8'h40;
  localparam logic [7:0] BLACK  = 8'h80;

  // Section markers that open the board and move parts of a packet
  localparam logic [7:0] GRID_HEADER = 8'b11_01_01_01;
  localparam logic [7:0] MOVE_HEADER = 8'b11_10_10_10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRID,
    ST_WAIT_MH,
    ST_MOVE_HI,
    ST_MOVE_LO,
    ST_START,
    ST_DRAIN
  } loader_state_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_GRID_HDR   = 3'd1,
    ERR_SHORT_GRID = 3'd2,
    ERR_MOVE_HDR   = 3'd3,
    ERR_NO_MOVES   = 3'd4,
    ERR_ODD_BYTE   = 3'd5,
    ERR_OVERFLOW   = 3'd6
  } err_code_e;

endpackage

// File: rtl/spi_packet_loader.sv
// rtl/spi_packet_loader.sv - parses SPI packets into board and move memories, then starts the core
module spi_packet_loader
  import tpu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    MOVE_WIDTH  = 16,
  parameter int                    MAX_MOVES   = 220,
  parameter logic [DATA_WIDTH-1:0] GRID_HEADER = DATA_WIDTH'(tpu_pkg::GRID_HEADER),
  parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = DATA_WIDTH'(tpu_pkg::MOVE_HEADER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_iv,
  input  logic [DATA_WIDTH-1:0] spi_id,
  output logic                  grid_we,
  output logic [5:0]            grid_addr,
  output logic [DATA_WIDTH-1:0] grid_wdata,
  output logic                  move_we,
  output logic [7:0]            move_addr,
  output logic [MOVE_WIDTH-1:0] move_wdata,
  input  logic                  core_busy,
  output logic                  core_start,
  output logic [7:0]            move_count,
  output logic                  err,
  output logic [2:0]            err_code,
  output logic                  loading
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_MOVES);

  loader_state_e         state_q, state_d;
  logic [5:0]            gcnt_q, gcnt_d;
  logic [7:0]            mcnt_q, mcnt_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  grid_we_q, grid_we_d;
  logic [5:0]            grid_addr_q, grid_addr_d;
  logic [DATA_WIDTH-1:0] grid_wdata_q, grid_wdata_d;
  logic                  move_we_q, move_we_d;
  logic [7:0]            move_addr_q, move_addr_d;
  logic [MOVE_WIDTH-1:0] move_wdata_q, move_wdata_d;
  logic                  core_start_q, core_start_d;
  logic [7:0]            move_count_q, move_count_d;
  logic                  err_q, err_d;
  err_code_e             err_code_q, err_code_d;

  // Packet parser: next state, counters, write ports and error bookkeeping
  always_comb begin
    state_d      = state_q;
    gcnt_d       = gcnt_q;
    mcnt_d       = mcnt_q;
    hi_d         = hi_q;
    grid_we_d    = 1'b0;
    grid_addr_d  = grid_addr_q;
    grid_wdata_d = grid_wdata_q;
    move_we_d    = 1'b0;
    move_addr_d  = move_addr_q;
    move_wdata_d = move_wdata_q;
    core_start_d = 1'b0;
    move_count_d = move_count_q;
    err_d        = err_q;
    err_code_d   = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (spi_iv) begin
          if (spi_id == GRID_HEADER) begin
            state_d = ST_GRID;
            gcnt_d  = 6'd0;
            err_d   = 1'b0;
          end else begin
            state_d    = ST_DRAIN;
            err_d      = 1'b1;
            err_code_d = ERR_GRID_HDR;
          end
        end
      end

      ST_GRID: begin
        if (spi_iv) begin
          grid_we_d    = 1'b1;
          grid_addr_d  = gcnt_q;
          grid_wdata_d = spi_id;
          // The square counter stops at 63 rather than wrapping back to 0
          if (gcnt_q == 6'd63) begin
            state_d = ST_WAIT_MH;
          end else begin
            gcnt_d = gcnt_q + 6'd1;
          end
        end else begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_SHORT_GRID;
        end
      end

      ST_WAIT_MH: begin
        if (spi_iv && (spi_id == MOVE_HEADER)) begin
          state_d = ST_MOVE_HI;
          mcnt_d  = 8'd0;
        end else begin
          state_d    = spi_iv ? ST_DRAIN : ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_MOVE_HDR;
        end
      end

      ST_MOVE_HI: begin
        if (spi_iv) begin
          if (mcnt_q == MAX_CNT) begin
            state_d    = ST_DRAIN;
            err_d      = 1'b1;
            err_code_d = ERR_OVERFLOW;
          end else begin
            hi_d    = spi_id;
            state_d = ST_MOVE_LO;
          end
        end else if (mcnt_q != 8'd0) begin
          state_d = ST_START;
        end else begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_NO_MOVES;
        end
      end

      ST_MOVE_LO: begin
        if (spi_iv) begin
          move_we_d    = 1'b1;
          move_addr_d  = mcnt_q;
          move_wdata_d = MOVE_WIDTH'({hi_q, spi_id});
          mcnt_d       = mcnt_q + 8'd1;
          state_d      = ST_MOVE_HI;
        end else begin
          // The captured high byte is simply dropped; nothing is written
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_ODD_BYTE;
        end
      end

      ST_START: begin
        if (!core_busy) begin
          core_start_d = 1'b1;
          move_count_d = mcnt_q;
          state_d      = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (!spi_iv) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset wins over any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gcnt_q       <= '0;
      mcnt_q       <= '0;
      hi_q         <= '0;
      grid_we_q    <= 1'b0;
      grid_addr_q  <= '0;
      grid_wdata_q <= '0;
      move_we_q    <= 1'b0;
      move_addr_q  <= '0;
      move_wdata_q <= '0;
      core_start_q <= 1'b0;
      move_count_q <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      mcnt_q       <= mcnt_d;
      hi_q         <= hi_d;
      grid_we_q    <= grid_we_d;
      grid_addr_q  <= grid_addr_d;
      grid_wdata_q <= grid_wdata_d;
      move_we_q    <= move_we_d;
      move_addr_q  <= move_addr_d;
      move_wdata_q <= move_wdata_d;
      core_start_q <= core_start_d;
      move_count_q <= move_count_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign grid_we    = grid_we_q;
  assign grid_addr  = grid_addr_q;
  assign grid_wdata = grid_wdata_q;
  assign move_we    = move_we_q;
  assign move_addr  = move_addr_q;
  assign move_wdata = move_wdata_q;
  assign core_start = core_start_q;
  assign move_count = move_count_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign loading    = (state_q == ST_GRID)    || (state_q == ST_WAIT_MH) ||
                      (state_q == ST_MOVE_HI) || (state_q == ST_MOVE_LO);

endmodule

// File: tb/tb_spi_packet_loader.sv
// tb/tb_spi_packet_loader.sv - randomized and directed bench with packet-level reference model
module tb_spi_packet_loader;
  import tpu_pkg::*;

  localparam int MAXM = 220;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_iv = 1'b0;
  logic [7:0]  spi_id = 8'h00;
  logic        core_busy = 1'b0;
  logic        grid_we;
  logic [5:0]  grid_addr;
  logic [7:0]  grid_wdata;
  logic        move_we;
  logic [7:0]  move_addr;
  logic [15:0] move_wdata;
  logic        core_start;
  logic [7:0]  move_count;
  logic        err;
  logic [2:0]  err_code;
  logic        loading;

  spi_packet_loader dut (
    .clk        (clk),
    .rst        (rst),
    .spi_iv     (spi_iv),
    .spi_id     (spi_id),
    .grid_we    (grid_we),
    .grid_addr  (grid_addr),
    .grid_wdata (grid_wdata),
    .move_we    (move_we),
    .move_addr  (move_addr),
    .move_wdata (move_wdata),
    .core_busy  (core_busy),
    .core_start (core_start),
    .move_count (move_count),
    .err        (err),
    .err_code   (err_code),
    .loading    (loading)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected traffic and status, produced by the packet-level model
  logic [13:0] exp_grid[$];
  logic [23:0] exp_move[$];
  int          exp_starts = 0;
  logic [7:0]  exp_move_count = 8'd0;
  logic        exp_err = 1'b0;
  logic [2:0]  exp_code = 3'd0;

  // Observed traffic
  logic [7:0]  grid_mem [64];
  logic [15:0] move_mem [256];
  int          grid_we_cnt = 0;
  int          move_we_cnt = 0;
  int          start_cnt = 0;
  logic        prev_start = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_err(input logic [2:0] code);
    exp_err  = 1'b1;
    exp_code = code;
  endtask

  // Outcome of one contiguous burst of valid bytes, derived from packet layout
  task automatic model_burst(input bq_t b);
    int n, m, nm;
    n = b.size();
    if (n == 0) return;
    if (b[0] != GRID_HEADER) begin
      set_err(3'd1);
      return;
    end
    exp_err = 1'b0;
    for (int i = 0; i < 64 && i < n - 1; i++) exp_grid.push_back({6'(i), b[1+i]});
    if (n - 1 < 64) begin
      set_err(3'd2);
      return;
    end
    if (n == 65 || b[65] != MOVE_HEADER) begin
      set_err(3'd3);
      return;
    end
    m  = n - 66;
    nm = (m > 2 * MAXM) ? MAXM : m / 2;
    for (int k = 0; k < nm; k++) exp_move.push_back({8'(k), b[66+2*k], b[67+2*k]});
    if (m > 2 * MAXM)  set_err(3'd6);
    else if (m == 0)   set_err(3'd4);
    else if (m % 2)    set_err(3'd5);
    else begin
      exp_starts++;
      exp_move_count = 8'(nm);
    end
  endtask

  // Compare process: every write and start pulse is matched against the model
  always @(negedge clk) begin
    if (grid_we) begin
      checks++;
      if (exp_grid.size() == 0) begin
        errors++;
        $display("FAIL grid_unexpected actual %0h:%0h expected none", grid_addr, grid_wdata);
      end else begin
        logic [13:0] e;
        e = exp_grid.pop_front();
        if ({grid_addr, grid_wdata} !== e) begin
          errors++;
          $display("FAIL grid_write actual %0h expected %0h", {grid_addr, grid_wdata}, e);
        end
      end
      checks++;
      if (!loading) begin
        errors++;
        $display("FAIL loading_on_grid actual 0 expected 1");
      end
      grid_mem[grid_addr] = grid_wdata;
      grid_we_cnt++;
    end
    if (move_we) begin
      checks++;
      if (exp_move.size() == 0) begin
        errors++;
        $display("FAIL move_unexpected actual %0h:%0h expected none", move_addr, move_wdata);
      end else begin
        logic [23:0] e;
        e = exp_move.pop_front();
        if ({move_addr, move_wdata} !== e) begin
          errors++;
          $display("FAIL move_write actual %0h expected %0h", {move_addr, move_wdata}, e);
        end
      end
      move_mem[move_addr] = move_wdata;
      move_we_cnt++;
    end
    if (core_start) begin
      start_cnt++;
      checks++;
      if (core_busy || prev_start || start_cnt > exp_starts || move_count !== exp_move_count) begin
        errors++;
        $display("FAIL core_start actual busy=%0d prev=%0d n=%0d cnt=%0d expected busy=0 prev=0 n<=%0d cnt=%0d",
                 core_busy, prev_start, start_cnt, move_count, exp_starts, exp_move_count);
      end
    end
    prev_start = core_start;
  end

  // Drive one burst; optionally assert reset on the byte at index rst_at
  task automatic send_burst(input bq_t b, input int rst_at);
    for (int i = 0; i < b.size(); i++) begin
      @(posedge clk);
      #1;
      spi_iv = 1'b1;
      spi_id = b[i];
      rst    = (i == rst_at);
      if (rst_at >= 0 && i == rst_at + 1) begin
        @(negedge clk);
        check("rst_grid_we", int'(grid_we), 0);
        check("rst_move_we", int'(move_we), 0);
        check("rst_start", int'(core_start), 0);
        check("rst_move_count", int'(move_count), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_loading", int'(loading), 0);
      end
    end
    @(posedge clk);
    #1;
    spi_iv = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic end_checks(input string tag);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_grid_left"}, exp_grid.size(), 0);
    check({tag, "_move_left"}, exp_move.size(), 0);
    check({tag, "_starts"}, start_cnt, exp_starts);
    check({tag, "_move_count"}, int'(move_count), int'(exp_move_count));
    check({tag, "_err"}, int'(err), int'(exp_err));
    check({tag, "_err_code"}, int'(err_code), int'(exp_code));
    check({tag, "_loading"}, int'(loading), 0);
  endtask

  task automatic run_packet(input string tag, input bq_t b, input int busy_cycles);
    int starts_before;
    starts_before = exp_starts;
    model_burst(b);
    core_busy = (busy_cycles > 0);
    send_burst(b, -1);
    if (busy_cycles > 0) begin
      repeat (busy_cycles - 1) @(posedge clk);
      #1;
      core_busy = 1'b0;
      if (exp_starts != starts_before) begin
        @(negedge clk);
        check({tag, "_start_early"}, int'(core_start), 0);
        @(negedge clk);
        check({tag, "_start_on_release"}, int'(core_start), 1);
      end
    end
    end_checks(tag);
  endtask

  function automatic logic [7:0] board_sq(input int a);
    logic [7:0] back [8];
    int row, col;
    back = '{ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK};
    row = a / 8;
    col = a % 8;
    case (row)
      0:       return WHITE | back[col];
      1:       return WHITE | PAWN;
      6:       return BLACK | PAWN;
      7:       return BLACK | back[col];
      default: return EMPTY;
    endcase
  endfunction

  function automatic bq_t prefix(input bit random_grid);
    bq_t q;
    q.push_back(GRID_HEADER);
    for (int i = 0; i < 64; i++) q.push_back(random_grid ? 8'($urandom_range(0, 255)) : board_sq(i));
    q.push_back(MOVE_HEADER);
    return q;
  endfunction

  function automatic bq_t random_packet(input int kind);
    bq_t q;
    logic [7:0] v;
    int len;
    q = prefix(1'b1);
    case (kind)
      0: repeat (2 * $urandom_range(1, 5)) q.push_back(8'($urandom_range(0, 255)));
      1: repeat (2 * $urandom_range(0, 4) + 1) q.push_back(8'($urandom_range(0, 255)));
      2: begin
        len = $urandom_range(1, 64);
        while (q.size() > len) void'(q.pop_back());
      end
      3: begin
        v = 8'($urandom_range(0, 255));
        if (v == GRID_HEADER) v = 8'h00;
        q[0] = v;
      end
      4: begin
        v = 8'($urandom_range(0, 255));
        if (v == MOVE_HEADER) v = 8'h00;
        q[65] = v;
        if ($urandom_range(0, 1) == 1) void'(q.pop_back());
      end
      default: ;
    endcase
    return q;
  endfunction

  initial begin
    bq_t std, b;
    int g0, m0, s0, kind;

    std = prefix(1'b0);
    std.push_back(8'h01);
    std.push_back(8'hB0);
    std.push_back(8'hDA);
    std.push_back(8'h40);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_grid_we", int'(grid_we), 0);
    check("reset_move_we", int'(move_we), 0);
    check("reset_start", int'(core_start), 0);
    check("reset_move_count", int'(move_count), 0);
    check("reset_err", int'(err), 0);
    check("reset_err_code", int'(err_code), 0);
    check("reset_loading", int'(loading), 0);

    // Standard packet
    run_packet("std", std, 0);
    check("std_grid0", int'(grid_mem[0]), 8'h44);
    check("std_grid63", int'(grid_mem[63]), 8'h84);
    check("std_move0", int'(move_mem[0]), 16'h01B0);
    check("std_move1", int'(move_mem[1]), 16'hDA40);
    check("std_count", int'(move_count), 2);
    check("std_starts", start_cnt, 1);

    // Core busy for 50 cycles after the packet ends
    run_packet("busy", std, 50);
    check("busy_starts", start_cnt, 2);

    // Bad grid header, then recovery
    g0 = grid_we_cnt;
    b = {8'h00, 8'h11, 8'h22};
    run_packet("badhdr", b, 0);
    check("badhdr_err", int'(err), 1);
    check("badhdr_code", int'(err_code), 1);
    check("badhdr_writes", grid_we_cnt - g0, 0);
    run_packet("recover", std, 0);
    check("recover_err", int'(err), 0);

    // Short grid of 30 squares
    g0 = grid_we_cnt;
    s0 = start_cnt;
    b = prefix(1'b0);
    while (b.size() > 31) void'(b.pop_back());
    run_packet("short", b, 0);
    check("short_code", int'(err_code), 2);
    check("short_writes", grid_we_cnt - g0, 30);
    check("short_starts", start_cnt - s0, 0);

    // Three move bytes
    m0 = move_we_cnt;
    b = prefix(1'b0);
    b.push_back(8'h01);
    b.push_back(8'hB0);
    b.push_back(8'hDA);
    run_packet("odd", b, 0);
    check("odd_code", int'(err_code), 5);
    check("odd_writes", move_we_cnt - m0, 1);

    // 221 moves overflows the buffer
    m0 = move_we_cnt;
    b = prefix(1'b1);
    repeat (2 * (MAXM + 1)) b.push_back(8'($urandom_range(0, 255)));
    run_packet("ovf", b, 0);
    check("ovf_code", int'(err_code), 6);
    check("ovf_writes", move_we_cnt - m0, MAXM);

    // Reset while grid square 40 is on the wire
    s0 = start_cnt;
    for (int i = 0; i < 40; i++) exp_grid.push_back({6'(i), std[1+i]});
    exp_move_count = 8'd0;
    exp_err = 1'b0;
    exp_code = 3'd0;
    b = std;
    for (int i = 0; i < 42; i++) void'(b.pop_front());
    model_burst(b);
    send_burst(std, 41);
    end_checks("rstmid");
    check("rstmid_starts", start_cnt - s0, 0);

    // Randomized packets of every outcome class
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 5);
      b = random_packet(kind);
      run_packet("rand", b, (kind == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 9)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_packet_loader.md
SPI_PACKET_LOADER -- requirements
Module: spi_packet_loader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, SPI byte width; MOVE_WIDTH, default 16, move word width; MAX_MOVES, default 220, move buffer depth; GRID_HEADER, default 8'b11_01_01_01, grid section marker; MOVE_HEADER, default 8'b11_10_10_10, move section marker.
REQ-002 Ports SHALL be: clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-003 spi_iv  in  1  byte valid; spi_id  in  DATA_WIDTH  byte data.
REQ-004 grid_we  out  1; grid_addr  out  6; grid_wdata  out  DATA_WIDTH  square write port to core board memory.
REQ-005 move_we  out  1; move_addr  out  8; move_wdata  out  MOVE_WIDTH  move buffer write port.
REQ-006 core_busy  in  1  core running; core_start  out  1  one-cycle start pulse; move_count  out  8  moves loaded, held stable from core_start until next packet.
REQ-007 err  out  1  sticky error; err_code  out  3  cause; loading  out  1  high from first accepted header byte to packet end.

Function
REQ-008 FSM states SHALL be IDLE, GRID, WAIT_MH, MOVE_HI, MOVE_LO, START, DRAIN.
REQ-009 IDLE: spi_iv=1 with spi_id=GRID_HEADER -> GRID, square counter=0; any other valid byte -> DRAIN, err_code=1 (bad grid header).
REQ-010 GRID: each valid byte SHALL be written to grid_addr=counter one cycle later (grid_we registered); after byte 63 -> WAIT_MH.
REQ-011 spi_iv low in GRID before 64 bytes -> IDLE, err_code=2 (short grid); board writes already issued are not retracted.
REQ-012 WAIT_MH: valid byte = MOVE_HEADER -> MOVE_HI, move counter=0; other byte -> DRAIN, err_code=3.
REQ-013 MOVE_HI captures move high byte; MOVE_LO captures low byte and issues move_we next cycle with move_wdata={hi,lo}, move_addr=counter, then counter+1.
REQ-014 spi_iv low in MOVE_HI with counter>=1 -> START; counter=0 -> IDLE, err_code=4 (no moves).
REQ-015 spi_iv low in MOVE_LO -> IDLE, err_code=5 (odd byte); the half move SHALL NOT be written.
REQ-016 Move byte pair arriving with counter=MAX_MOVES -> DRAIN, err_code=6 (overflow); no write beyond address MAX_MOVES-1.
REQ-017 START: hold until core_busy=0, then pulse core_start exactly one cycle with move_count=counter, -> IDLE.
REQ-018 spi_iv low in WAIT_MH -> IDLE, err_code=3.
REQ-019 DRAIN: discard bytes until spi_iv=0, then -> IDLE.
REQ-020 Any new packet beginning while core_busy=1 SHALL still be accepted; only core_start waits.
REQ-021 err SHALL be set with the first error and cleared by the next GRID_HEADER accepted in IDLE; err_code holds the latest cause.
REQ-022 Byte counters SHALL not wrap; counter widths fixed at 6 bits (grid) and 8 bits (moves).

Reset
REQ-023 rst=1 at a clk edge SHALL force IDLE and zero all outputs and counters, including mid-packet; move_count=0, err=0, err_code=0.
REQ-024 After reset release, bytes of an interrupted packet SHALL be treated per REQ-009 (non-header -> DRAIN).

Structure
REQ-025 Piece encodings (EMPTY, KING..PAWN, WHITE, BLACK), GRID_HEADER, MOVE_HEADER, the state enum and err_code enum SHALL live in the shared package tpu_pkg.
REQ-026 No sub-module; single FSM plus counters and registered write ports.

Verification
REQ-027 Standard stream: header, 64-byte initial board, MOVE_HEADER, 01 B0 DA 40, iv low -> 64 grid writes (addr 0 = 8'h44, addr 63 = 8'h84), moves 16'h01B0 at 0 and 16'hDA40 at 1, move_count=2, one core_start.
REQ-028 Same stream with core_busy=1 for 50 cycles after iv low -> core_start delayed until first cycle core_busy=0, exactly one pulse.
REQ-029 First byte 8'h00 -> err=1, err_code=1, no grid_we; next valid packet clears err and loads normally.
REQ-030 iv drops after 30 grid bytes -> err_code=2, 30 grid writes, no core_start.
REQ-031 Three move bytes then iv low -> err_code=5, only move 0 written; 221 moves -> err_code=6, 220 writes.
REQ-032 rst asserted at grid byte 40 -> outputs zero next cycle, remaining bytes drained, no core_start.
